// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator and its receive-side classifier:
// mode codes, classifier FSM encoding and the LFSR step used by both sides.
package led_pattern_pkg;

    localparam logic [1:0] MODE_COUNT = 2'b00;
    localparam logic [1:0] MODE_SCAN  = 2'b01;
    localparam logic [1:0] MODE_LFSR  = 2'b10;
    localparam logic [1:0] MODE_ALT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TRACK  = 2'b01,
        LOCKED = 2'b10
    } state_e;

    // Taps 8,6,5,4 shifted in at bit 0; must stay identical to the generator.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Candidate priority when several rules fit one transition: ALT > LFSR > SCAN > COUNT.
    function automatic logic [1:0] pick_mode(input logic [3:0] match);
        if (match[MODE_ALT])  return MODE_ALT;
        if (match[MODE_LFSR]) return MODE_LFSR;
        if (match[MODE_SCAN]) return MODE_SCAN;
        return MODE_COUNT;
    endfunction

endpackage

// File: rtl/led_pattern_classifier_matcher.sv
// Combinational transition checker: reports which generator modes could have
// produced the step prev_val -> next_val. Bit index equals the mode code.
module led_transition_matcher
    import led_pattern_pkg::*;
(
    input  logic [7:0] prev_val,
    input  logic [7:0] next_val,
    output logic [3:0] match
);

    logic prev_onehot;
    logic scan_shift;
    logic scan_wrap;
    logic count_hit;
    logic lfsr_hit;
    logic alt_hit;

    assign prev_onehot = (prev_val != 8'h00) && ((prev_val & (prev_val - 8'h01)) == 8'h00);
    assign scan_shift  = prev_onehot && (next_val != 8'h00) &&
                         ((next_val == {prev_val[6:0], 1'b0}) || (next_val == {1'b0, prev_val[7:1]}));
    // The scanner restarts at bit 0 from an empty bus or after walking off the top.
    assign scan_wrap   = ((prev_val == 8'h00) || (prev_val == 8'h80)) && (next_val == 8'h01);

    assign count_hit = (next_val == prev_val + 8'h01);
    // An all-zero LFSR is a lock-up state; the generator reseeds it with 0x01.
    assign lfsr_hit  = (next_val == lfsr_next(prev_val)) || ((prev_val == 8'h00) && (next_val == 8'h01));
    assign alt_hit   = (next_val == 8'h55) || ((prev_val == 8'h55) && (next_val == 8'hAA));

    assign match = {alt_hit, lfsr_hit, scan_shift | scan_wrap, count_hit};

endmodule

// File: rtl/led_pattern_classifier.sv
// Identifies the running LED generator mode by checking each bus change against
// the four transition rules and locking after LOCK_COUNT consistent changes.
module led_pattern_classifier
    import led_pattern_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] led_in,
    output logic [1:0] detected_mode,
    output logic       locked,
    output logic       lock_pulse,
    output logic [7:0] mismatch_count
);

    localparam logic [3:0] LOCK_C    = 4'(LOCK_COUNT);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    logic [7:0] sample_q;
    logic [7:0] last_q;
    logic       has_last;
    state_e     state;
    logic [1:0] cand;
    logic [3:0] conf;
    logic [7:0] idle_cnt;

    logic [3:0] match;
    logic       change;
    logic       cand_hit;
    logic [1:0] best_mode;

    led_transition_matcher u_matcher (
        .prev_val (last_q),
        .next_val (sample_q),
        .match    (match)
    );

    assign change        = has_last && (sample_q != last_q);
    assign cand_hit      = match[cand];
    assign best_mode     = pick_mode(match);
    assign detected_mode = cand;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q       <= 8'h00;
            last_q         <= 8'h00;
            has_last       <= 1'b0;
            state          <= IDLE;
            cand           <= MODE_COUNT;
            conf           <= 4'd0;
            idle_cnt       <= 8'd0;
            locked         <= 1'b0;
            lock_pulse     <= 1'b0;
            mismatch_count <= 8'd0;
        end else if (enable) begin
            sample_q   <= led_in;
            lock_pulse <= 1'b0;
            if (!has_last) begin
                // Re-arm: take a reference value, nothing to compare against yet.
                last_q   <= sample_q;
                has_last <= 1'b1;
                idle_cnt <= 8'd0;
            end else if (change) begin
                last_q   <= sample_q;
                idle_cnt <= 8'd0;
                if ((state != IDLE) && cand_hit) begin
                    if (state == TRACK) begin
                        conf <= conf + 4'd1;
                        if (conf + 4'd1 == LOCK_C) begin
                            state      <= LOCKED;
                            locked     <= 1'b1;
                            lock_pulse <= 1'b1;
                        end
                    end
                end else begin
                    if (state == LOCKED) begin
                        mismatch_count <= sat_inc8(mismatch_count);
                        locked         <= 1'b0;
                    end
                    if (match != 4'b0000) begin
                        cand  <= best_mode;
                        conf  <= 4'd1;
                        state <= TRACK;
                    end else begin
                        conf  <= 4'd0;
                        state <= IDLE;
                    end
                end
            end else if (idle_cnt == TIMEOUT_C - 8'd1) begin
                // Bus stalled: drop any lock and wait for a fresh reference value.
                state    <= IDLE;
                conf     <= 4'd0;
                locked   <= 1'b0;
                has_last <= 1'b0;
                idle_cnt <= TIMEOUT_C;
            end else begin
                idle_cnt <= idle_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_classifier.sv
// Scoreboard bench for led_pattern_classifier: expectations are queued as values
// are driven and compared when the DUT evaluates them two edges later.
`timescale 1ns/1ps
module tb_led_pattern_classifier;

    localparam int LOCK_COUNT = 4;
    localparam int TIMEOUT    = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] led_in;
    logic [1:0] detected_mode;
    logic       locked;
    logic       lock_pulse;
    logic [7:0] mismatch_count;

    led_pattern_classifier #(
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .led_in         (led_in),
        .detected_mode  (detected_mode),
        .locked         (locked),
        .lock_pulse     (lock_pulse),
        .mismatch_count (mismatch_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pulse_seen = 0;
    always @(negedge clk) if (lock_pulse === 1'b1) pulse_seen <= pulse_seen + 1;

    typedef struct {
        int         due;
        logic [7:0] val;
        logic       el;
        logic [1:0] em;
        bit         cm;
        logic [7:0] emm;
        logic       ep;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_due = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic sb_service();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.due != cyc) begin
                n_fail++;
                $display("FAIL sb_timing val=0x%02h serviced at cycle %0d, required %0d", e.val, cyc, e.due);
            end
            n_checks++;
            if (locked !== e.el) begin
                n_fail++;
                $display("FAIL sb_locked val=0x%02h got %0b required %0b", e.val, locked, e.el);
            end
            n_checks++;
            if (lock_pulse !== e.ep) begin
                n_fail++;
                $display("FAIL sb_lock_pulse val=0x%02h got %0b required %0b", e.val, lock_pulse, e.ep);
            end
            n_checks++;
            if (mismatch_count !== e.emm) begin
                n_fail++;
                $display("FAIL sb_mismatch_count val=0x%02h got %0d required %0d", e.val, mismatch_count, e.emm);
            end
            if (e.cm) begin
                n_checks++;
                if (detected_mode !== e.em) begin
                    n_fail++;
                    $display("FAIL sb_mode val=0x%02h got %02b required %02b", e.val, detected_mode, e.em);
                end
            end
        end
    endtask

    // Drive one bus value (called at a negedge) and queue what it must produce.
    task automatic step(input logic [7:0] v, input logic el, input logic [1:0] em, input bit cm,
                        input logic [7:0] emm, input logic ep, input int hold);
        exp_t e;
        led_in = v;
        e.due = cyc + 2;
        e.val = v;
        e.el  = el;
        e.em  = em;
        e.cm  = cm;
        e.emm = emm;
        e.ep  = ep;
        sb.push_back(e);
        last_due = e.due;
        repeat (hold) begin
            @(negedge clk);
            sb_service();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            sb_service();
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        sb.delete();
        enable = 1'b1;
        led_in = 8'h00;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        led_in = 8'h00;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({detected_mode, locked, lock_pulse, mismatch_count} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs got mode=%02b locked=%0b pulse=%0b mm=%0d required all 0",
                     detected_mode, locked, lock_pulse, mismatch_count);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({detected_mode, locked, lock_pulse, mismatch_count} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_static_bus got mode=%02b locked=%0b pulse=%0b mm=%0d required all 0",
                     detected_mode, locked, lock_pulse, mismatch_count);
        end
    endtask

    task automatic test_count();
        int base;
        do_reset();
        base = pulse_seen;
        step(8'h10, 1'b0, 2'b00, 1'b1, 8'd0, 1'b0, 16);
        step(8'h11, 1'b0, 2'b00, 1'b1, 8'd0, 1'b0, 16);
        step(8'h12, 1'b0, 2'b00, 1'b1, 8'd0, 1'b0, 16);
        step(8'h13, 1'b0, 2'b00, 1'b1, 8'd0, 1'b0, 16);
        step(8'h14, 1'b1, 2'b00, 1'b1, 8'd0, 1'b1, 16);
        drain();
        n_checks++;
        if (pulse_seen - base != 1) begin
            n_fail++;
            $display("FAIL count_pulse_total got %0d required 1", pulse_seen - base);
        end
        n_checks++;
        if (locked !== 1'b1 || detected_mode !== 2'b00) begin
            n_fail++;
            $display("FAIL count_held got locked=%0b mode=%02b required 1/00", locked, detected_mode);
        end
    endtask

    task automatic test_scan_vs_lfsr();
        do_reset();
        step(8'h00, 1'b0, 2'b00, 1'b1, 8'd0, 1'b0, 1);
        step(8'h01, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        step(8'h02, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        step(8'h04, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        step(8'h08, 1'b1, 2'b10, 1'b1, 8'd0, 1'b1, 1);
        step(8'h10, 1'b0, 2'b01, 1'b1, 8'd1, 1'b0, 1);
        step(8'h20, 1'b0, 2'b01, 1'b1, 8'd1, 1'b0, 1);
        step(8'h40, 1'b0, 2'b01, 1'b1, 8'd1, 1'b0, 1);
        step(8'h80, 1'b1, 2'b01, 1'b1, 8'd1, 1'b1, 1);
        drain();
    endtask

    task automatic test_lfsr();
        do_reset();
        step(8'h01, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        step(8'h02, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        step(8'h04, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        step(8'h08, 1'b1, 2'b10, 1'b1, 8'd0, 1'b1, 1);
        step(8'h11, 1'b1, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        step(8'h23, 1'b1, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        drain();
    endtask

    task automatic test_alt_mismatch();
        logic [7:0] mm;
        do_reset();
        step(8'h55, 1'b0, 2'b11, 1'b1, 8'd0, 1'b0, 1);
        step(8'hAA, 1'b0, 2'b11, 1'b1, 8'd0, 1'b0, 1);
        step(8'h55, 1'b0, 2'b11, 1'b1, 8'd0, 1'b0, 1);
        step(8'hAA, 1'b1, 2'b11, 1'b1, 8'd0, 1'b1, 1);
        step(8'h55, 1'b1, 2'b11, 1'b1, 8'd0, 1'b0, 1);
        // 0x56 is a valid count step, so the candidate moves to COUNT.
        step(8'h56, 1'b0, 2'b00, 1'b1, 8'd1, 1'b0, 1);
        mm = 8'd1;
        for (int k = 0; k < 300; k++) begin
            step(8'h55, 1'b0, 2'b11, 1'b1, mm, 1'b0, 1);
            step(8'hAA, 1'b0, 2'b11, 1'b1, mm, 1'b0, 1);
            step(8'h55, 1'b0, 2'b11, 1'b1, mm, 1'b0, 1);
            step(8'hAA, 1'b1, 2'b11, 1'b1, mm, 1'b1, 1);
            step(8'h55, 1'b1, 2'b11, 1'b1, mm, 1'b0, 1);
            if (mm != 8'd255) mm = mm + 8'd1;
            step(8'h00, 1'b0, 2'b00, 1'b0, mm, 1'b0, 1);
        end
        drain();
        n_checks++;
        if (mismatch_count !== 8'd255) begin
            n_fail++;
            $display("FAIL alt_mismatch_saturate got %0d required 255", mismatch_count);
        end
    endtask

    task automatic lock_alt();
        do_reset();
        step(8'h55, 1'b0, 2'b11, 1'b1, 8'd0, 1'b0, 1);
        step(8'hAA, 1'b0, 2'b11, 1'b1, 8'd0, 1'b0, 1);
        step(8'h55, 1'b0, 2'b11, 1'b1, 8'd0, 1'b0, 1);
        step(8'hAA, 1'b1, 2'b11, 1'b1, 8'd0, 1'b1, 1);
        for (int i = 0; i < 10 && cyc < last_due; i++) begin
            @(negedge clk);
            sb_service();
        end
    endtask

    task automatic test_stall();
        lock_alt();
        repeat (TIMEOUT - 1) @(negedge clk);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_before_timeout got locked=%0b required 1", locked);
        end
        @(negedge clk);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_at_timeout got locked=%0b required 0", locked);
        end
        n_checks++;
        if (mismatch_count !== 8'd0) begin
            n_fail++;
            $display("FAIL stall_mismatch_count got %0d required 0", mismatch_count);
        end
    endtask

    task automatic test_enable_gating();
        lock_alt();
        repeat (20) @(negedge clk);
        enable = 1'b0;
        led_in = 8'h13;
        repeat (100) @(negedge clk);
        led_in = 8'hAA;
        repeat (100) @(negedge clk);
        n_checks++;
        if (locked !== 1'b1 || detected_mode !== 2'b11) begin
            n_fail++;
            $display("FAIL enable_hold got locked=%0b mode=%02b required 1/11", locked, detected_mode);
        end
        enable = 1'b1;
        repeat (TIMEOUT - 21) @(negedge clk);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_idle_count_held got locked=%0b required 1", locked);
        end
        @(negedge clk);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_timeout got locked=%0b required 0", locked);
        end
    endtask

    task automatic test_reset_mid_track();
        do_reset();
        step(8'h55, 1'b0, 2'b11, 1'b1, 8'd0, 1'b0, 1);
        step(8'hAA, 1'b0, 2'b11, 1'b1, 8'd0, 1'b0, 1);
        step(8'h55, 1'b0, 2'b11, 1'b1, 8'd0, 1'b0, 1);
        step(8'hAA, 1'b1, 2'b11, 1'b1, 8'd0, 1'b1, 1);
        step(8'h00, 1'b0, 2'b00, 1'b0, 8'd1, 1'b0, 1);
        step(8'h55, 1'b0, 2'b11, 1'b1, 8'd1, 1'b0, 1);
        step(8'hAA, 1'b0, 2'b11, 1'b1, 8'd1, 1'b0, 1);
        drain();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({detected_mode, locked, lock_pulse, mismatch_count} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset got mode=%02b locked=%0b pulse=%0b mm=%0d required all 0",
                     detected_mode, locked, lock_pulse, mismatch_count);
        end
        @(negedge clk);
        led_in = 8'h00;
        reset  = 1'b0;
        step(8'h01, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        step(8'h02, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        step(8'h04, 1'b0, 2'b10, 1'b1, 8'd0, 1'b0, 1);
        step(8'h08, 1'b1, 2'b10, 1'b1, 8'd0, 1'b1, 1);
        drain();
    endtask

    initial begin
        test_reset();
        test_count();
        test_scan_vs_lfsr();
        test_lfsr();
        test_alt_mismatch();
        test_stall();
        test_enable_gating();
        test_reset_mid_track();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
